instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Assembles MIPS-subset 32-bit instruction words from a stream of symbolic micro-ops (mnemonic index plus operand fields). It is the inverse of the control decoder and covers the same instruction subset. Sits between the test/program generator and instruction memory: it feeds the instruction loader and produces self-checking stimulus for the datapath. Uses valid/ready on both sides and an internal FIFO.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >=2)
CNT_W, 16, width of emitted-word counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  micro-op present
in_ready  out  1  encoder can accept (FIFO not full)
in_mnem  in  5  mnemonic index (table below)
in_rs  in  5  source reg
in_rt  in  5  target reg
in_rd  in  5  dest reg
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer takes head word
out_word  out  32  encoded instruction at FIFO head
out_illegal  out  1  head entry came from unsupported mnemonic
emit_cnt  out  CNT_W  words popped since reset, wraps

Behaviour:
- Mnemonic table, with op/fn in hex:
  - R-type (op 00): 0 sllv fn04; 1 srlv 06; 2 srav 07; 3 jr 08; 4 add 20; 5 addu 21; 6 sub 22; 7 subu 23; 8 and 24; 9 or 25; 10 xor 26; 11 nor 27; 22 mult 18.
  - J/branch: 12 j op02; 13 beq 04; 14 bne 05; 15 blez 06; 16 bgtz 07.
  - I-type: 17 addi 08; 18 addiu 09; 19 andi 0C; 20 ori 0D; 21 xori 0E; 23 lw 23; 24 sw 2B.
  - 25..31 illegal.
- R-type word = {6'h00, rs, rt, rd, 5'b0, fn}.
  - jr forces rt = rd = 0.
  - mult forces rd = 0.
- j word = {6'h02, in_target}.
- I-type and branch word = {op, rs, rt, imm}.
  - blez/bgtz force rt = 0.
- Illegal mnemonic: accepted normally; stores word 32'h00000000 with illegal flag = 1. Never stalls, never dropped.
- Encoding is combinational on the inputs and is written into the FIFO at the accept edge (in_valid & in_ready).
- Latency: an accepted micro-op into an empty FIFO appears on out_word/out_valid the next cycle.
- Pop on out_valid & out_ready. emit_cnt increments on each pop and wraps from all-ones to 0.
- in_ready = !full, registered-count based.
  - When full, a same-cycle pop does not admit a push: in_ready stays 0 that cycle.
- Push and pop in the same cycle when neither full nor empty: occupancy unchanged, order preserved.
- out_word and out_illegal are undefined-but-stable when out_valid = 0; the bench checks them only when valid.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Reset (any time, including mid-stream) clears pointers, occupancy and emit_cnt. In-flight entries are discarded.
  - Reset values: out_valid 0, in_ready 0 while reset is asserted, 1 after it deasserts, out_word 0, out_illegal 0, emit_cnt 0.

Optional Feature:
- Macro: ENCODER_STATS_EN.
- Defined:
  - Extra output port illegal_cnt [7:0]: counts accepted illegal mnemonics, saturates at 8'hFF, reset 0.
  - Extra output port fifo_full_seen: sticky, set when occupancy reaches DEPTH, cleared only by reset.
- Undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
- After reset, push add rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_valid=1, out_word=32'h00221820, out_illegal=0; following cycle emit_cnt=1.
- Push addi rt=5 rs=0 imm=16'h0010, then j target=26'h0000100, then lw rt=8 rs=29 imm=4, then sw same operands, out_ready=1 -> words in order: 20050010, 08000100, 8FA80004, AFA80004.
- Push jr rs=31 with rt=rd=7 -> 03E00008 (rt/rd ignored). Push mult rs=4 rt=5 rd=9 -> 00850018.
- Push mnem=27 -> out_word=00000000, out_illegal=1; with ENCODER_STATS_EN, illegal_cnt=1.
- Hold out_ready=0, push DEPTH words -> in_ready=0 after the DEPTH-th accept. Raise out_ready with in_valid=1: no push in the pop cycle; then drain and confirm FIFO order and emit_cnt=DEPTH.
- Assert reset with 2 entries queued -> out_valid=0 and emit_cnt=0 immediately (async). After release, the first new push is the first word out.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS-subset 32-bit instruction words from symbolic
// micro-ops (mnemonic index plus operand fields). The encoded word enters an
// internal FIFO on accept and is presented to the consumer with valid/ready.
// Illegal mnemonics are accepted and produce a zero word flagged as illegal.
// Optional statistics outputs (illegal_cnt, fifo_full_seen) exist only when
// the macro ENCODER_STATS_EN is defined.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_mnem,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_illegal,
  output logic [CNT_W-1:0] emit_cnt
`ifdef ENCODER_STATS_EN
  ,
  output logic [7:0]       illegal_cnt,
  output logic             fifo_full_seen
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // Instruction format selected by the mnemonic.
  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_J   = 2'd1,
    FMT_I   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  fmt_e        fmt;
  logic [5:0]  op_code;
  logic [5:0]  fn_code;
  logic        force_rt0;
  logic        force_rd0;
  logic [4:0]  enc_rt;
  logic [4:0]  enc_rd;
  logic [31:0] enc_word;
  logic        enc_illegal;

  // FIFO state.
  logic [31:0]      mem_word_q [DEPTH];
  logic [DEPTH-1:0] mem_ill_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] emit_q, emit_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Mnemonic lookup: format, opcode/function and the operand fields that the
  // instruction ignores (forced to zero in the encoded word).
  always_comb begin
    fmt       = FMT_BAD;
    op_code   = 6'h00;
    fn_code   = 6'h00;
    force_rt0 = 1'b0;
    force_rd0 = 1'b0;
    case (in_mnem)
      5'd0:  begin fmt = FMT_R; fn_code = 6'h04; end
      5'd1:  begin fmt = FMT_R; fn_code = 6'h06; end
      5'd2:  begin fmt = FMT_R; fn_code = 6'h07; end
      5'd3:  begin fmt = FMT_R; fn_code = 6'h08; force_rt0 = 1'b1; force_rd0 = 1'b1; end
      5'd4:  begin fmt = FMT_R; fn_code = 6'h20; end
      5'd5:  begin fmt = FMT_R; fn_code = 6'h21; end
      5'd6:  begin fmt = FMT_R; fn_code = 6'h22; end
      5'd7:  begin fmt = FMT_R; fn_code = 6'h23; end
      5'd8:  begin fmt = FMT_R; fn_code = 6'h24; end
      5'd9:  begin fmt = FMT_R; fn_code = 6'h25; end
      5'd10: begin fmt = FMT_R; fn_code = 6'h26; end
      5'd11: begin fmt = FMT_R; fn_code = 6'h27; end
      5'd22: begin fmt = FMT_R; fn_code = 6'h18; force_rd0 = 1'b1; end
      5'd12: begin fmt = FMT_J; op_code = 6'h02; end
      5'd13: begin fmt = FMT_I; op_code = 6'h04; end
      5'd14: begin fmt = FMT_I; op_code = 6'h05; end
      5'd15: begin fmt = FMT_I; op_code = 6'h06; force_rt0 = 1'b1; end
      5'd16: begin fmt = FMT_I; op_code = 6'h07; force_rt0 = 1'b1; end
      5'd17: begin fmt = FMT_I; op_code = 6'h08; end
      5'd18: begin fmt = FMT_I; op_code = 6'h09; end
      5'd19: begin fmt = FMT_I; op_code = 6'h0C; end
      5'd20: begin fmt = FMT_I; op_code = 6'h0D; end
      5'd21: begin fmt = FMT_I; op_code = 6'h0E; end
      5'd23: begin fmt = FMT_I; op_code = 6'h23; end
      5'd24: begin fmt = FMT_I; op_code = 6'h2B; end
      default: begin fmt = FMT_BAD; end
    endcase
  end

  // Field assembly for the selected format.
  always_comb begin
    enc_rt      = force_rt0 ? 5'd0 : in_rt;
    enc_rd      = force_rd0 ? 5'd0 : in_rd;
    enc_word    = 32'h0000_0000;
    enc_illegal = 1'b0;
    case (fmt)
      FMT_R:   enc_word = {6'h00, in_rs, enc_rt, enc_rd, 5'd0, fn_code};
      FMT_J:   enc_word = {op_code, in_target};
      FMT_I:   enc_word = {op_code, in_rs, enc_rt, in_imm};
      default: enc_illegal = 1'b1;
    endcase
  end

  // Handshakes. Ready depends only on registered occupancy, so a pop in a
  // full cycle cannot admit a push in that same cycle.
  assign full     = (occ_q == DEPTH_OCC);
  assign empty    = (occ_q == '0);
  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;

  // Head entry is masked to zero while empty so the idle outputs are stable.
  assign out_word    = empty ? 32'h0000_0000 : mem_word_q[rd_ptr_q];
  assign out_illegal = empty ? 1'b0 : mem_ill_q[rd_ptr_q];
  assign emit_cnt    = emit_q;

  // Next-state for pointers, occupancy and the pop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    emit_d   = emit_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      emit_d   = emit_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards every queued entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      emit_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      emit_q   <= emit_d;
    end
  end

  // FIFO storage: written at the accept edge, contents need no reset because
  // validity is tracked by the occupancy counter.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= enc_word;
      mem_ill_q[wr_ptr_q]  <= enc_illegal;
    end
  end

`ifdef ENCODER_STATS_EN
  logic [7:0] ill_cnt_q, ill_cnt_d;
  logic       full_seen_q, full_seen_d;

  // Saturating illegal-accept counter and sticky full indicator.
  always_comb begin
    ill_cnt_d   = ill_cnt_q;
    full_seen_d = full_seen_q || full;
    if (push && enc_illegal && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ill_cnt_q   <= 8'd0;
      full_seen_q <= 1'b0;
    end else begin
      ill_cnt_q   <= ill_cnt_d;
      full_seen_q <= full_seen_d;
    end
  end

  assign illegal_cnt    = ill_cnt_q;
  assign fifo_full_seen = full_seen_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios followed by randomized
// traffic checked against a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_mnem, in_rs, in_rt, in_rd;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_illegal;
  logic [CNT_W-1:0] emit_cnt;
`ifdef ENCODER_STATS_EN
  logic [7:0]       illegal_cnt;
  logic             fifo_full_seen;
`endif

  always #5 clock = ~clock;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_illegal(out_illegal),
    .emit_cnt(emit_cnt)
`ifdef ENCODER_STATS_EN
    , .illegal_cnt(illegal_cnt), .fifo_full_seen(fifo_full_seen)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: opcode/function per mnemonic index (0 for illegal slots).
  localparam logic [7:0] CODE [32] = '{
    8'h04, 8'h06, 8'h07, 8'h08, 8'h20, 8'h21, 8'h22, 8'h23,
    8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h04, 8'h05, 8'h06,
    8'h07, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h0E, 8'h18, 8'h23,
    8'h2B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // Returns {illegal, word} for a micro-op.
  function automatic logic [32:0] ref_enc(input int m, input logic [4:0] rs, rt, rd,
                                          input logic [15:0] imm, input logic [25:0] tg);
    logic [5:0] c;
    c = CODE[m][5:0];
    if (m == 3) begin rt = 5'd0; rd = 5'd0; end
    if (m == 22) rd = 5'd0;
    if (m == 15 || m == 16) rt = 5'd0;
    if (m <= 11 || m == 22) return {1'b0, 6'h00, rs, rt, rd, 5'd0, c};
    if (m == 12) return {1'b0, c, tg};
    if (m <= 24) return {1'b0, c, rs, rt, imm};
    return {1'b1, 32'h0};
  endfunction

  // Drive one micro-op for a single cycle; caller is just after a rising edge.
  task automatic send(input logic [4:0] m, rs, rt, rd, input logic [15:0] imm,
                      input logic [25:0] tg);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg;
    in_valid = 1'b1;
    @(negedge clock);
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a head word, check it and pop it.
  task automatic expect_word(input string tag, input logic [31:0] w, input logic ill);
    bit seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) begin seen = 1; break; end
      @(posedge clock); #1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_word"}, out_word, w);
      chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
  endtask

  logic [32:0] q [$];
  int unsigned emit_m;
  int unsigned ill_m;
  bit          seen_m;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_word", out_word, 32'h0);
    chk("post_rst_ill", {31'd0, out_illegal}, 32'd0);
    chk("post_rst_emit", {16'd0, emit_cnt}, 32'd0);
    @(posedge clock); #1;

    // add with single-cycle latency
    in_mnem = 5'd4; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    chk("add_valid_before", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_word", out_word, 32'h00221820);
    chk("add_ill", {31'd0, out_illegal}, 32'd0);
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("add_emit", {16'd0, emit_cnt}, 32'd1);
    chk("add_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;

    // I-type, jump, load, store in order
    send(5'd17, 5'd0, 5'd5, 5'd0, 16'h0010, 26'h0);
    send(5'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100);
    send(5'd23, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    send(5'd24, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    expect_word("addi", 32'h20050010, 1'b0);
    expect_word("j", 32'h08000100, 1'b0);
    expect_word("lw", 32'h8FA80004, 1'b0);
    expect_word("sw", 32'hAFA80004, 1'b0);

    // forced-zero fields and illegal mnemonic
    send(5'd3, 5'd31, 5'd7, 5'd7, 16'h0, 26'h0);
    send(5'd22, 5'd4, 5'd5, 5'd9, 16'h0, 26'h0);
    send(5'd27, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
    expect_word("jr", 32'h03E00008, 1'b0);
    expect_word("mult", 32'h00850018, 1'b0);
    expect_word("illegal", 32'h00000000, 1'b1);
`ifdef ENCODER_STATS_EN
    chk("illegal_cnt", {24'd0, illegal_cnt}, 32'd1);
`endif
    @(negedge clock);
    chk("emit_8", {16'd0, emit_cnt}, 32'd8);
    @(posedge clock); #1;

    // fill to DEPTH, then pop while pushing: no push admitted that cycle
    for (int i = 0; i < DEPTH; i++) send(5'd18, 5'd1, 5'd2, 5'd0, 16'(i + 1), 26'h0);
    @(negedge clock);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1;
    in_mnem = 5'd18; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0055; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("full_pop_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", out_word, 32'h24220001);
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 1; i < DEPTH; i++) expect_word("full_drain", 32'h24220000 | 32'(i + 1), 1'b0);
    @(negedge clock);
    chk("full_no_extra", {31'd0, out_valid}, 32'd0);
    chk("emit_full", {16'd0, emit_cnt}, 32'(8 + DEPTH));
`ifdef ENCODER_STATS_EN
    chk("full_seen", {31'd0, fifo_full_seen}, 32'd1);
`endif
    @(posedge clock); #1;

    // asynchronous reset with two entries queued
    send(5'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    send(5'd5, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_emit", {16'd0, emit_cnt}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_word", out_word, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    send(5'd9, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
    expect_word("after_rst", 32'h00642825, 1'b0);
    @(negedge clock);
    chk("after_rst_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;

    // randomized traffic against the queue model
    emit_m = 1; ill_m = 0; seen_m = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit do_push, do_pop;
      logic [32:0] e;
      in_mnem = 5'($urandom_range(0, 31));
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_imm = 16'($urandom); in_target = 26'($urandom);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clock);
      chk("rnd_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("rnd_word", out_word, q[0][31:0]);
        chk("rnd_ill", {31'd0, out_illegal}, {31'd0, q[0][32]});
      end
      chk("rnd_emit", {16'd0, emit_cnt}, emit_m & 32'hFFFF);
`ifdef ENCODER_STATS_EN
      chk("rnd_ill_cnt", {24'd0, illegal_cnt}, ill_m);
      chk("rnd_full_seen", {31'd0, fifo_full_seen}, {31'd0, seen_m});
`endif
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() != 0);
      e = ref_enc(int'(in_mnem), in_rs, in_rt, in_rd, in_imm, in_target);
      @(posedge clock);
      if (q.size() == DEPTH) seen_m = 1;
      if (do_pop) begin void'(q.pop_front()); emit_m++; end
      if (do_push) begin
        q.push_back(e);
        if (e[32] && ill_m < 255) ill_m++;
      end
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
